// File: rtl/ball_game_ctrl_if.sv
// ============================================================================
//  Module   : ball_game_ctrl_if
//  Purpose  : Bundles the ball-game controller's frame/player inputs and
//             sprite/score outputs into one connection.
//  Ports    : master - drives frame_tick, start_btn, hit_pulse; observes
//                      the ball position, score, lives and overlay flags.
//             slave  - the controller side (mirror of master).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ball_game_ctrl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       hit_pulse;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       ball_send_trigger;

  modport master (
    output frame_tick, start_btn, hit_pulse,
    input  ball_x, ball_y, score, lives, game_over, ball_send_trigger
  );

  modport slave (
    input  frame_tick, start_btn, hit_pulse,
    output ball_x, ball_y, score, lives, game_over, ball_send_trigger
  );
endinterface

`default_nettype wire

// File: rtl/ball_game_ctrl.sv
// ============================================================================
//  Module   : ball_game_ctrl
//  Purpose  : Frame-rate ball game controller. Moves the ball once per
//             frame_tick, bounces it off the side walls and off a detected
//             player hit, hands it to a peer when it leaves through the top,
//             and counts misses at the bottom until game over.
//  Ports    : clk   - pixel-domain clock
//             reset - asynchronous active-high reset
//             bus   - ball_game_ctrl_if.slave (frame_tick, start_btn,
//                     hit_pulse in; ball_x/y, score, lives, game_over,
//                     ball_send_trigger out)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_game_ctrl #(
  parameter int BALL_SIZE   = 20,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LIVES       = 3,
  parameter int SEND_FRAMES = 30,
  parameter int SPEED       = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  ball_game_ctrl_if.slave  bus
);

  localparam int                 c_CNT_W    = $clog2(SEND_FRAMES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SEND_FRAMES - 1);
  localparam logic signed [10:0] c_SPEED    = 11'(SPEED);
  localparam logic signed [10:0] c_X_MAX_S  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] c_Y_MAX_S  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]         c_X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]         c_Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]         c_X_CTR    = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]         c_Y_CTR    = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [1:0]         c_LIVES    = 2'(LIVES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_SEND = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic [9:0]         r_x, w_x_n;
  logic [9:0]         r_y, w_y_n;
  logic               r_dx_neg, w_dx_neg_n;  // direction bits: speed magnitude is fixed
  logic               r_dy_neg, w_dy_neg_n;
  logic [7:0]         r_score, w_score_n;
  logic [1:0]         r_lives, w_lives_n;
  logic               r_hit, w_hit_n;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_n;

  logic               w_bounce;
  logic signed [10:0] w_x_sum;
  logic signed [10:0] w_y_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_x      <= c_X_CTR;
      r_y      <= c_Y_CTR;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_score  <= 8'd0;
      r_lives  <= c_LIVES;
      r_hit    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_x      <= w_x_n;
      r_y      <= w_y_n;
      r_dx_neg <= w_dx_neg_n;
      r_dy_neg <= w_dy_neg_n;
      r_score  <= w_score_n;
      r_lives  <= w_lives_n;
      r_hit    <= w_hit_n;
      r_cnt    <= w_cnt_n;
    end
  end

  // The hit is resolved before the move, so a bounce already uses the
  // flipped vertical direction in this frame's y step.
  always_comb begin
    w_bounce = (r_hit | bus.hit_pulse) & ~r_dy_neg;
    w_x_sum  = $signed({1'b0, r_x}) + (r_dx_neg ? -c_SPEED : c_SPEED);
    w_y_sum  = $signed({1'b0, r_y}) + ((r_dy_neg | w_bounce) ? -c_SPEED : c_SPEED);
  end

  always_comb begin
    w_state_n  = r_state;
    w_x_n      = r_x;
    w_y_n      = r_y;
    w_dx_neg_n = r_dx_neg;
    w_dy_neg_n = r_dy_neg;
    w_score_n  = r_score;
    w_lives_n  = r_lives;
    w_hit_n    = r_hit;
    w_cnt_n    = r_cnt;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (bus.start_btn) begin
          w_state_n  = ST_PLAY;
          w_x_n      = c_X_CTR;
          w_y_n      = c_Y_CTR;
          w_dx_neg_n = 1'b0;
          w_dy_neg_n = 1'b0;
          w_score_n  = 8'd0;
          w_lives_n  = c_LIVES;
          w_hit_n    = 1'b0;
          w_cnt_n    = '0;
        end
      end

      ST_PLAY: begin
        if (bus.frame_tick) begin
          w_hit_n = 1'b0;
          if (w_bounce) begin
            w_dy_neg_n = 1'b1;
            if (r_score < 8'd99) w_score_n = r_score + 8'd1;
          end

          if (w_x_sum <= 11'sd0) begin
            w_x_n      = 10'd0;
            w_dx_neg_n = 1'b0;
          end else if (w_x_sum >= c_X_MAX_S) begin
            w_x_n      = c_X_MAX;
            w_dx_neg_n = 1'b1;
          end else begin
            w_x_n = w_x_sum[9:0];
          end

          if (w_y_sum < 11'sd0) begin
            // Ball leaves through the top: y is held until it comes back.
            w_state_n = ST_SEND;
            w_cnt_n   = '0;
          end else if (w_y_sum >= c_Y_MAX_S) begin
            w_lives_n = r_lives - 2'd1;
            if (r_lives <= 2'd1) begin
              w_state_n = ST_OVER;
              w_y_n     = c_Y_MAX;
            end else begin
              w_x_n      = c_X_CTR;
              w_y_n      = c_Y_CTR;
              w_dy_neg_n = 1'b0;
            end
          end else begin
            w_y_n = w_y_sum[9:0];
          end
        end else if (bus.hit_pulse) begin
          w_hit_n = 1'b1;
        end
      end

      ST_SEND: begin
        if (bus.frame_tick) begin
          if (r_cnt == c_CNT_LAST) begin
            w_state_n  = ST_PLAY;
            w_y_n      = 10'd0;
            w_dy_neg_n = 1'b0;
            w_cnt_n    = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end

      default: w_state_n = ST_IDLE;
    endcase
  end

  // Flags decode straight from the state register so an asynchronous reset
  // drops them without waiting for a clock edge.
  assign bus.ball_x            = r_x;
  assign bus.ball_y            = r_y;
  assign bus.score             = r_score;
  assign bus.lives             = r_lives;
  assign bus.game_over         = (r_state == ST_OVER);
  assign bus.ball_send_trigger = (r_state == ST_SEND);

endmodule

`default_nettype wire

// File: doc/ball_game_ctrl.md
BALL_GAME_CTRL -- requirements
Module: ball_game_ctrl

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 20: ball sprite edge length in pixels.
REQ-002 SHALL have parameter H_ACTIVE, default 640: visible width in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible height in pixels.
REQ-004 SHALL have parameter LIVES, default 3: misses allowed before game over (1..3).
REQ-005 SHALL have parameter SEND_FRAMES, default 30: frames for which ball_send_trigger is held.
REQ-006 SHALL have parameter SPEED, default 2: pixels moved per frame on each axis.
REQ-007 SHALL have port clk, input, 1: the single pixel-domain clock.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port frame_tick, input, 1: one-cycle pulse at the start of vertical blanking.
REQ-010 SHALL have port start_btn, input, 1: one-cycle start pulse, already debounced.
REQ-011 SHALL have port hit_pulse, input, 1: ball hit-area pixel coincides with a detected player pixel.
REQ-012 SHALL have port ball_x, output, 10: ball top-left x.
REQ-013 SHALL have port ball_y, output, 10: ball top-left y.
REQ-014 SHALL have port score, output, 8: binary score, 0..99.
REQ-015 SHALL have port lives, output, 2: remaining lives.
REQ-016 SHALL have port game_over, output, 1: game-over overlay enable.
REQ-017 SHALL have port ball_send_trigger, output, 1: ball handed to peer, sprite hidden.

Function
REQ-018 SHALL implement an FSM with states IDLE, PLAY, SEND and OVER.
REQ-019 SHALL change ball_x, ball_y, score and lives only in the cycle after frame_tick, except on a start transition, so values stay constant during active video.
REQ-020 SHALL, in IDLE or OVER, on start_btn, go to PLAY the next cycle with score=0, lives=LIVES, ball at centre (H_ACTIVE/2-BALL_SIZE/2, V_ACTIVE/2-BALL_SIZE/2), dx=+SPEED, dy=+SPEED.
REQ-021 SHALL ignore start_btn in PLAY and SEND.
REQ-022 SHALL, in PLAY, set a hit latch on any hit_pulse, including a hit_pulse coincident with frame_tick.
REQ-023 SHALL process each PLAY frame_tick in this order: hit, x move, y move, boundary checks.
REQ-024 SHALL, on a PLAY frame_tick with the hit latch set and dy>0, negate dy and increment score, saturating at 99; the latch SHALL then clear whether or not a bounce occurred.
REQ-025 SHALL compute x_next = ball_x+dx in signed 11-bit arithmetic.
REQ-026 SHALL, if x_next <= 0, clamp ball_x to 0 and set dx=+SPEED.
REQ-027 SHALL, if x_next >= H_ACTIVE-BALL_SIZE, clamp ball_x to H_ACTIVE-BALL_SIZE and set dx=-SPEED.
REQ-028 SHALL, if y_next = ball_y+dy < 0 (top exit), enter SEND and assert ball_send_trigger the next cycle.
REQ-029 SHALL, if y_next >= V_ACTIVE-BALL_SIZE (miss), decrement lives.
REQ-030 SHALL, on a miss where lives reaches 0, enter OVER; otherwise it SHALL respawn the ball at centre with dy=+SPEED and stay in PLAY.
REQ-031 SHALL, in SEND, hold ball_send_trigger=1, count frame_ticks, and after the SEND_FRAMES-th tick return to PLAY with ball_y=0, dy=+SPEED and ball_x unchanged; hit_pulse SHALL be ignored in SEND.
REQ-032 SHALL, in OVER, hold game_over=1, freeze ball_x, ball_y and score, and keep ball_send_trigger=0.
REQ-033 SHALL never let ball_x exceed H_ACTIVE-BALL_SIZE or ball_y exceed V_ACTIVE-BALL_SIZE.

Reset
REQ-034 SHALL, on reset assertion, immediately set: state=IDLE, ball at centre (310,230), dx=dy=+SPEED, score=0, lives=LIVES, game_over=0, ball_send_trigger=0, hit latch and frame counter cleared.
REQ-035 SHALL, on reset mid-SEND or mid-OVER, drop ball_send_trigger or game_over immediately without waiting for a clock edge.

Verification
REQ-036 SHALL verify: reset, then start_btn, then 5 frame_ticks -> ball=(320,240), score=0, state=PLAY.
REQ-037 SHALL verify: hit_pulse with dy=+2, then frame_tick -> dy=-2, score+1; with score=99 -> score stays 99.
REQ-038 SHALL verify: ball_x=619 with dx=+2, then frame_tick -> ball_x=620 and dx=-2; ball_x=1 with dx=-2 -> ball_x=0 and dx=+2.
REQ-039 SHALL verify: ball_y=1 with dy=-2, then tick -> ball_send_trigger=1 for 30 ticks, then ball_y=0, dy=+2, trigger=0.
REQ-040 SHALL verify: three misses -> lives 2, then 1, then 0, with game_over=1 after the third; start_btn -> PLAY, score=0, lives=3.
REQ-041 SHALL verify: reset asserted during SEND -> ball_send_trigger=0 asynchronously, and all outputs equal the REQ-034 values.
